// File: rtl/axis_loopback_gen_chk.sv
// axis_loopback_gen_chk: framed AXI4-Stream pattern generator plus an independent checker
// with optional pseudo-random tready throttling, used for DMA loopback bring-up.
module axis_loopback_gen_chk #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_W       = 16,
  parameter int START_COUNT = 32
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_i,
  input  logic                    enable_i,
  input  logic                    mode_i,
  input  logic                    stall_en_i,
  input  logic [LEN_W-1:0]        frame_len_i,
  input  logic [15:0]             frame_cnt_i,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             tx_frames_o,
  output logic [31:0]             rx_frames_o,
  output logic [15:0]             err_cnt_o,
  output logic                    err_o
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int REP = (DATA_WIDTH + 31) / 32;

  typedef enum logic [1:0] {IDLE, WAIT, SEND, DONE} state_t;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic m, input logic [31:0] c, input logic [31:0] l);
    logic [REP*32-1:0] r, z;
    r = {REP{l}};
    z = '0;
    z[31:0] = c;
    return m ? r[DATA_WIDTH-1:0] : z[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [31:0] lfsr32(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  state_t state_q, state_d;
  logic mode_q, mode_d, err_q, err_d, done_q, done_d, rdy_q;
  logic rv_q, rv_d, rl_q, rl_d;
  logic [LEN_W-1:0] len_q, len_d, tx_beat_q, tx_beat_d, rx_beat_q, rx_beat_d, last_idx;
  logic [15:0] cnt_q, cnt_d, err_cnt_q, err_cnt_d, stall_q, stall_d;
  logic [31:0] wait_q, wait_d, tx_ctr_q, tx_ctr_d, tx_lfsr_q, tx_lfsr_d;
  logic [31:0] rx_ctr_q, rx_ctr_d, rx_lfsr_q, rx_lfsr_d, tx_frames_q, tx_frames_d, rx_frames_q, rx_frames_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic start, tx_hs, tx_last, rx_hs, rx_exp_last, rx_bad;
  logic unused_strb;

  assign unused_strb   = ^s_axis_tstrb;
  assign last_idx      = (len_q == '0) ? '0 : len_q - 1'b1;
  assign m_axis_tvalid = state_q == SEND;
  assign m_axis_tdata  = pat(mode_q, tx_ctr_q, tx_lfsr_q);
  assign m_axis_tstrb  = {SW{m_axis_tvalid}};
  assign m_axis_tlast  = m_axis_tvalid && tx_beat_q == last_idx;
  assign s_axis_tready = rdy_q && !(stall_en_i && stall_q[0]);
  assign busy_o        = state_q != IDLE;
  assign done_o        = done_q;
  assign tx_frames_o   = tx_frames_q;
  assign rx_frames_o   = rx_frames_q;
  assign err_cnt_o     = err_cnt_q;
  assign err_o         = err_q;

  always_comb begin
    start       = state_q == IDLE && enable_i;
    tx_hs       = m_axis_tvalid && m_axis_tready;
    tx_last     = tx_hs && tx_beat_q == last_idx;
    rx_hs       = s_axis_tvalid && s_axis_tready;
    rx_exp_last = rx_beat_q == last_idx;
    rx_bad      = rv_q && (rd_q != pat(mode_q, rx_ctr_q, rx_lfsr_q) || rl_q != rx_exp_last);
    state_d     = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = WAIT;
      WAIT:    if (wait_q == 32'(START_COUNT)) state_d = SEND;
      SEND:    if (tx_last) state_d = (cnt_q != 16'd0 && tx_frames_q + 32'd1 == {16'd0, cnt_q}) ? DONE :
                                      enable_i ? SEND : IDLE;
      DONE:    if (!enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mode_d      = start ? mode_i : mode_q;
    len_d       = start ? frame_len_i : len_q;
    cnt_d       = start ? frame_cnt_i : cnt_q;
    wait_d      = state_q == WAIT ? wait_q + 32'd1 : '0;
    tx_ctr_d    = start ? '0 : tx_hs ? tx_ctr_q + 32'd1 : tx_ctr_q;
    tx_lfsr_d   = start ? 32'd1 : tx_hs ? lfsr32(tx_lfsr_q) : tx_lfsr_q;
    tx_beat_d   = (start || tx_last) ? '0 : tx_hs ? tx_beat_q + 1'b1 : tx_beat_q;
    tx_frames_d = start ? '0 : tx_frames_q + {31'd0, tx_last};
    // received beats are registered first and checked one cycle later
    rv_d        = rx_hs && !start;
    rd_d        = s_axis_tdata;
    rl_d        = s_axis_tlast;
    rx_ctr_d    = start ? '0 : rv_q ? rx_ctr_q + 32'd1 : rx_ctr_q;
    rx_lfsr_d   = start ? 32'd1 : rv_q ? lfsr32(rx_lfsr_q) : rx_lfsr_q;
    rx_beat_d   = start ? '0 : rv_q ? ((rl_q || rx_exp_last) ? '0 : rx_beat_q + 1'b1) : rx_beat_q;
    rx_frames_d = start ? '0 : rx_frames_q + {31'd0, rv_q && rl_q};
    err_cnt_d   = start ? '0 : err_cnt_q + {15'd0, rx_bad && err_cnt_q != 16'hFFFF};
    err_d       = !start && (err_q || rx_bad);
    done_d      = !start && (done_q || (state_q == DONE && rx_frames_q == tx_frames_q));
    stall_d     = {stall_q[14:0], stall_q[15] ^ stall_q[13] ^ stall_q[12] ^ stall_q[10]};
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i)
    if (sys_rst_i) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      tx_ctr_q    <= '0;
      tx_lfsr_q   <= 32'd1;
      tx_beat_q   <= '0;
      tx_frames_q <= '0;
      rv_q        <= 1'b0;
      rd_q        <= '0;
      rl_q        <= 1'b0;
      rx_ctr_q    <= '0;
      rx_lfsr_q   <= 32'd1;
      rx_beat_q   <= '0;
      rx_frames_q <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      stall_q     <= 16'hACE1;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      tx_ctr_q    <= tx_ctr_d;
      tx_lfsr_q   <= tx_lfsr_d;
      tx_beat_q   <= tx_beat_d;
      tx_frames_q <= tx_frames_d;
      rv_q        <= rv_d;
      rd_q        <= rd_d;
      rl_q        <= rl_d;
      rx_ctr_q    <= rx_ctr_d;
      rx_lfsr_q   <= rx_lfsr_d;
      rx_beat_q   <= rx_beat_d;
      rx_frames_q <= rx_frames_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
      stall_q     <= stall_d;
      rdy_q       <= 1'b1;
    end
endmodule

// File: tb/tb_axis_loopback_gen_chk.sv
// tb_axis_loopback_gen_chk: loopback bench with a beat scoreboard, run table and corner-case sequences.
module tb_axis_loopback_gen_chk;
  localparam int DW = 64;
  localparam int START = 3;

  typedef struct packed {logic [DW-1:0] d; logic last;} beat_t;
  typedef struct {logic m; int len; int cnt; logic st; int flip; int tx; int rx; int err; logic done;} vec_t;

  logic clk = 0, rst = 0, enable = 0, mode = 0, stall = 0;
  logic [15:0] flen = 0, fcnt = 0;
  logic m_tvalid, m_tready, m_tlast, s_tvalid, s_tready, s_tlast, busy, done, err_o;
  logic [DW-1:0] m_tdata, s_tdata;
  logic [DW/8-1:0] m_tstrb, s_tstrb;
  logic [31:0] tx_frames, rx_frames;
  logic [15:0] err_cnt;
  int flip_at = -1, last_at = -1, n_tx = 0, errors = 0, checks = 0;
  beat_t exp_q[$];
  vec_t tv[6];

  always #5 clk = ~clk;

  assign m_tready = s_tready;
  assign s_tvalid = m_tvalid;
  assign s_tstrb  = m_tstrb;
  assign s_tdata  = m_tdata ^ {{DW-1{1'b0}}, n_tx == flip_at};
  assign s_tlast  = m_tlast | (n_tx == last_at);

  axis_loopback_gen_chk #(.DATA_WIDTH(DW), .LEN_W(16), .START_COUNT(START)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .enable_i(enable), .mode_i(mode), .stall_en_i(stall),
    .frame_len_i(flen), .frame_cnt_i(fcnt),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .busy_o(busy), .done_o(done), .tx_frames_o(tx_frames), .rx_frames_o(rx_frames),
    .err_cnt_o(err_cnt), .err_o(err_o));

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) n_tx <= (rst || !enable) ? 0 : n_tx + int'(m_tvalid && m_tready);

  logic pv = 0, pl = 0;
  logic [DW-1:0] pd = '0;
  beat_t b;
  always @(negedge clk)
    if (rst) pv = 0;
    else begin
      if (pv) begin
        chk("hold_valid", DW'(m_tvalid), 1);
        chk("hold_data", m_tdata, pd);
        chk("hold_last", DW'(m_tlast), DW'(pl));
      end
      pv = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_tlast;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: unexpected beat data %0h", m_tdata);
        end else begin
          b = exp_q.pop_front();
          chk("sb_data", m_tdata, b.d);
          chk("sb_last", DW'(m_tlast), DW'(b.last));
          chk("sb_strb", DW'(m_tstrb), DW'(8'hFF));
        end
      end
    end

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, DW'(m_tvalid), 0);
    chk({tag, "_tdata"}, m_tdata, 0);
    chk({tag, "_tstrb"}, DW'(m_tstrb), 0);
    chk({tag, "_tlast"}, DW'(m_tlast), 0);
    chk({tag, "_tready"}, DW'(s_tready), 0);
    chk({tag, "_busy"}, DW'(busy), 0);
    chk({tag, "_done"}, DW'(done), 0);
    chk({tag, "_tx"}, DW'(tx_frames), 0);
    chk({tag, "_rx"}, DW'(rx_frames), 0);
    chk({tag, "_errcnt"}, DW'(err_cnt), 0);
    chk({tag, "_err"}, DW'(err_o), 0);
  endtask

  task automatic start_run(input logic m, input int len, input int cnt, input logic st, input int nb);
    logic [31:0] lf = 32'd1;
    int eff = (len == 0) ? 1 : len;
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back('{d: m ? {lf, lf} : DW'(i), last: (i % eff) == eff - 1});
      lf = {lf[30:0], lf[31] ^ lf[21] ^ lf[1] ^ lf[0]};
    end
    mode = m; flen = len[15:0]; fcnt = cnt[15:0]; stall = st; enable = 1;
    @(posedge clk); #1;
    chk("busy_start", DW'(busy), 1);
    chk("err_cleared", DW'(err_o), 0);
    chk("done_cleared", DW'(done), 0);
    chk("tvalid_wait", DW'(m_tvalid), 0);
    repeat (START) begin
      @(posedge clk); #1;
      chk("tvalid_wait", DW'(m_tvalid), 0);
    end
    @(posedge clk); #1;
    chk("tvalid_first", DW'(m_tvalid), 1);
  endtask

  task automatic wait_ntx(input int k);
    for (int c = 0; c < 3000 && n_tx < k; c++) @(negedge clk);
    chk("ntx_reached", DW'(n_tx >= k), 1);
  endtask

  task automatic stop_run();
    enable = 0;
    repeat (3) @(negedge clk);
    chk("busy_end", DW'(busy), 0);
  endtask

  initial begin
    logic [15:0] e1;
    tv[0] = '{1'b0, 4, 3, 1'b0, -1, 3, 3, 0, 1'b1};
    tv[1] = '{1'b1, 16, 10, 1'b1, -1, 10, 10, 0, 1'b1};
    tv[2] = '{1'b0, 4, 3, 1'b0, 5, 3, 3, 1, 1'b1};
    tv[3] = '{1'b1, 0, 2, 1'b0, -1, 2, 2, 0, 1'b1};
    tv[4] = '{1'b0, 1, 5, 1'b1, -1, 5, 5, 0, 1'b1};
    tv[5] = '{1'b1, 3, 2, 1'b1, -1, 2, 2, 0, 1'b1};
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    @(negedge clk);
    chk("tready_idle", DW'(s_tready), 1);
    for (int i = 0; i < 6; i++) begin
      flip_at = tv[i].flip;
      start_run(tv[i].m, tv[i].len, tv[i].cnt, tv[i].st, ((tv[i].len == 0) ? 1 : tv[i].len) * tv[i].cnt);
      for (int c = 0; c < 5000 && !done; c++) @(negedge clk);
      chk($sformatf("v%0d_done", i), DW'(done), DW'(tv[i].done));
      chk($sformatf("v%0d_tx", i), DW'(tx_frames), DW'(tv[i].tx));
      chk($sformatf("v%0d_rx", i), DW'(rx_frames), DW'(tv[i].rx));
      chk($sformatf("v%0d_errcnt", i), DW'(err_cnt), DW'(tv[i].err));
      chk($sformatf("v%0d_err", i), DW'(err_o), DW'(tv[i].err != 0));
      chk($sformatf("v%0d_sb_empty", i), DW'(exp_q.size()), 0);
      flip_at = -1;
      stop_run();
    end
    last_at = 2;
    start_run(0, 8, 3, 0, 24);
    wait_ntx(11);
    e1 = err_cnt;
    for (int c = 0; c < 500 && tx_frames != 3; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("early_err_nz", DW'(err_cnt != 0), 1);
    chk("early_resync", DW'(err_cnt), DW'(e1));
    chk("early_err", DW'(err_o), 1);
    chk("early_tx", DW'(tx_frames), 3);
    chk("early_sb_empty", DW'(exp_q.size()), 0);
    last_at = -1;
    stop_run();
    start_run(1, 4, 0, 0, 24);
    wait_ntx(22);
    enable = 0;
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    chk("cont_busy", DW'(busy), 0);
    repeat (3) @(negedge clk);
    chk("cont_tx", DW'(tx_frames), 6);
    chk("cont_rx", DW'(rx_frames), 6);
    chk("cont_errcnt", DW'(err_cnt), 0);
    chk("cont_done", DW'(done), 0);
    chk("cont_sb_empty", DW'(exp_q.size()), 0);
    start_run(0, 8, 4, 1, 32);
    wait_ntx(10);
    #2 rst = 1;
    #1 chk_zero("midrst");
    enable = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    start_run(0, 4, 3, 0, 12);
    for (int c = 0; c < 500 && !done; c++) @(negedge clk);
    chk("rerun_done", DW'(done), 1);
    chk("rerun_tx", DW'(tx_frames), 3);
    chk("rerun_rx", DW'(rx_frames), 3);
    chk("rerun_errcnt", DW'(err_cnt), 0);
    chk("rerun_sb_empty", DW'(exp_q.size()), 0);
    stop_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_loopback_gen_chk.md
# axis_loopback_gen_chk

Parametrised AXI4-Stream traffic generator and checker for DMA bring-up. The master side emits framed test traffic with a selectable data pattern. The slave side regenerates the expected pattern, checks every received beat and framing, and can throttle with pseudo-random backpressure. It sits in the AXI_DMA test builds. Master and slave are either looped back to each other or wrapped around the DMA datapath under test.

## Interface
Parameters:
- DATA_WIDTH, 32, tdata width; multiple of 8, range 8..256
- LEN_W, 16, width of frame_len_i
- START_COUNT, 32, idle cycles between enable sampled high and first tvalid; must be ≥1

Ports:
- sys_clk_i  in  1  single clock for all logic
- sys_rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  start/continue traffic
- mode_i  in  1  0 = incrementing counter, 1 = LFSR pattern
- stall_en_i  in  1  enable pseudo-random s_axis_tready throttling
- frame_len_i  in  LEN_W  beats per frame; 0 treated as 1
- frame_cnt_i  in  16  frames to send; 0 = continuous
- m_axis_tvalid / m_axis_tdata / m_axis_tstrb / m_axis_tlast  out  1 / DATA_WIDTH / DATA_WIDTH/8 / 1  master stream
- m_axis_tready  in  1
- s_axis_tvalid / s_axis_tdata / s_axis_tstrb / s_axis_tlast  in  1 / DATA_WIDTH / DATA_WIDTH/8 / 1  slave stream
- s_axis_tready  out  1
- busy_o  out  1  generator not in IDLE
- done_o  out  1  all frames sent and received (finite mode)
- tx_frames_o  out  32  frames accepted on master side
- rx_frames_o  out  32  frames received on slave side
- err_cnt_o  out  16  beat errors, saturating at 16'hFFFF
- err_o  out  1  sticky error flag

## Operation
- Generator FSM states: IDLE, WAIT, SEND, DONE.
- IDLE → WAIT when enable_i = 1. On this transition: sample mode_i, frame_len_i and frame_cnt_i; clear the counters, err_o and done_o. Inputs changed later are ignored until the next IDLE exit.
- WAIT counts START_COUNT cycles, then goes to SEND.
- SEND drives the master stream. It enters DONE after frame_cnt frames are accepted (finite mode). If enable_i is low at a tlast handshake, it returns to IDLE. Frames are never truncated.
- DONE sets done_o once rx_frames_o = tx_frames_o. Falling enable_i returns DONE → IDLE; done_o holds until the next IDLE exit.
- Pattern, mode 0: a beat counter starts at 0 and increments per accepted beat. It wraps modulo 2^min(DATA_WIDTH,32) and is zero-extended to DATA_WIDTH.
- Pattern, mode 1: 32-bit Fibonacci LFSR, taps 32,22,2,1, seed 32'h0000_0001. It advances per accepted beat and its value is replicated across DATA_WIDTH (truncated for widths below 32).
- Pattern continuity: the pattern state is reset on IDLE exit only; it runs on across frame boundaries.
- tstrb is all ones. tlast is asserted on beat frame_len−1 of each frame.
- AXIS rule: once tvalid is high, tvalid, tdata and tlast hold until the handshake.
- Checker: an independent copy of the pattern generator advances on each s-side handshake, plus a beat-in-frame counter.
  - A beat is in error if tdata ≠ expected, or if tlast ≠ (beat index = frame_len−1).
  - At most one error count per beat. An early tlast restarts the beat index at 0.
- s_axis_tready:
  - stall_en_i = 0: 1 whenever out of reset.
  - stall_en_i = 1: the inverse of bit 0 of a free-running 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) that advances every cycle.
- err_o sets on the first error and clears only on reset or IDLE exit.

## Timing
- Reset (asynchronous assert, synchronous release): all outputs are 0, including s_axis_tready; the FSM is in IDLE.
- The first m_axis_tvalid is high at edge START_COUNT+1 after the edge that samples enable_i high.
- Throughput: 1 beat/cycle when tready is held high. Consecutive frames have no bubble.
- err_cnt_o, err_o and rx_frames_o update on the edge after the offending or tlast handshake. tx_frames_o updates on the tlast handshake edge.
- done_o is high no later than 2 cycles after the last rx tlast handshake.
- Reset mid-frame aborts immediately. The next run restarts both patterns from their seeds.

## Test plan
- Loopback, mode 0, frame_len 4, frame_cnt 3, no stall → 12 beats with tdata 0..11, tlast on beats 3/7/11. tx = rx = 3, err_cnt 0, done_o high.
- Loopback, mode 1, DATA_WIDTH 64, frame_len 16, frame_cnt 10, stall_en_i = 1 → data stable under every stall. rx_frames 10, err_cnt 0.
- Force s_axis_tdata bit 0 inverted for one beat → err_cnt 1, err_o sticky, rx_frames unaffected.
- Force tlast early at beat 2 of a frame_len-8 frame → err_cnt ≥ 1, checker resynchronises on the next frame.
- Continuous mode, enable_i dropped mid-frame 5 → frame 5 completes, busy_o falls, tx_frames = 6.
- Assert sys_rst_i mid-frame → all outputs 0 the same cycle. Rerun from counter value 0 passes with err_cnt 0.
